// File: rtl/fmc_lpc_pattern.sv
// FMC LPC loopback pattern generator: drives static or walking-one/zero patterns
// onto the LA pins and accumulates sticky per-pin mismatches against the loopback.
module fmc_lpc_pattern #(
  parameter int unsigned NPINS = 68,
  parameter int unsigned DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [1:0]       mode,
  input  logic [NPINS-1:0] static_val,
  input  logic [DIV_W-1:0] div,
  input  logic [NPINS-1:0] la_in,
  output logic [NPINS-1:0] la_out,
  output logic             busy,
  output logic             done,
  output logic [7:0]       step,
  output logic [NPINS-1:0] err_mask
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [7:0]       LAST_STEP = 8'(NPINS - 1);
  localparam logic [NPINS-1:0] ONE_HOT0  = {{(NPINS-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [NPINS-1:0] la_out_q, la_out_d;
  logic [NPINS-1:0] err_q, err_d;
  logic [7:0]       step_q, step_d;
  logic [DIV_W-1:0] dwell_q, dwell_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             inv_q, inv_d;

  logic [NPINS-1:0] idle_val;
  logic             last_dwell;

  function automatic logic [NPINS-1:0] walk_pat(input logic [7:0] k, input logic inv);
    logic [NPINS-1:0] p;
    p = ONE_HOT0 << k;
    return inv ? ~p : p;
  endfunction

  assign idle_val   = (mode == 2'd1) ? static_val : '0;
  assign last_dwell = (dwell_q == div_q);

  // NOTE: every variable is given a default before the case so that no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d  = state_q;
    la_out_d = la_out_q;
    err_d    = err_q;
    step_d   = step_q;
    dwell_d  = dwell_q;
    div_d    = div_q;
    inv_d    = inv_q;

    case (state_q)
      S_IDLE: begin
        if (start && mode[1]) begin
          state_d  = S_RUN;
          step_d   = '0;
          dwell_d  = '0;
          err_d    = '0;
          div_d    = div;
          inv_d    = mode[0];
          la_out_d = walk_pat(8'd0, mode[0]);
        end else begin
          la_out_d = idle_val;
        end
      end

      S_RUN: begin
        // Abort wins over the compare/advance; pins keep the current pattern
        // for one cycle and IDLE restores its own value on the following edge.
        if (abort) begin
          state_d = S_IDLE;
        end else if (last_dwell) begin
          err_d   = err_q | (la_in ^ la_out_q);
          dwell_d = '0;
          if (step_q == LAST_STEP) begin
            state_d = S_DONE;
          end else begin
            step_d   = step_q + 8'd1;
            la_out_d = walk_pat(step_q + 8'd1, inv_q);
          end
        end else begin
          dwell_d = dwell_q + 1'b1;
        end
      end

      S_DONE: begin
        state_d  = S_IDLE;
        la_out_d = idle_val;
      end

      default: begin
        state_d  = S_IDLE;
        la_out_d = '0;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      la_out_q <= '0;
      err_q    <= '0;
      step_q   <= '0;
      dwell_q  <= '0;
      div_q    <= '0;
      inv_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      la_out_q <= la_out_d;
      err_q    <= err_d;
      step_q   <= step_d;
      dwell_q  <= dwell_d;
      div_q    <= div_d;
      inv_q    <= inv_d;
    end
  end

  assign la_out   = la_out_q;
  assign busy     = (state_q == S_RUN);
  assign done     = (state_q == S_DONE);
  assign step     = step_q;
  assign err_mask = err_q;

endmodule

// File: tb/tb_fmc_lpc_pattern.sv
// Directed scoreboard bench for fmc_lpc_pattern with a 4-pin loopback and a
// configurable stuck-at-0 fault on the returned pins.
module tb_fmc_lpc_pattern;

  localparam int NP = 4;
  localparam int DW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          abort;
  logic [1:0]    mode;
  logic [NP-1:0] static_val;
  logic [DW-1:0] div;
  logic [NP-1:0] la_in;
  logic [NP-1:0] la_out;
  logic          busy;
  logic          done;
  logic [7:0]    step;
  logic [NP-1:0] err_mask;
  logic [NP-1:0] stuck0;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [NP-1:0] la;
    logic          busy;
    logic          done;
    logic [7:0]    step;
    bit            chk_step;
  } exp_t;

  exp_t sb[$];

  fmc_lpc_pattern #(.NPINS(NP), .DIV_W(DW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .mode       (mode),
    .static_val (static_val),
    .div        (div),
    .la_in      (la_in),
    .la_out     (la_out),
    .busy       (busy),
    .done       (done),
    .step       (step),
    .err_mask   (err_mask)
  );

  always #5 clk = ~clk;

  // Zero-delay loopback with optional stuck-at-0 pins.
  assign la_in = la_out & ~stuck0;

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NP-1:0] pat(input int k, input bit inv);
    logic [NP-1:0] p;
    p = 4'b0001 << k;
    return inv ? ~p : p;
  endfunction

  task automatic push(input logic [NP-1:0] la, input logic b, input logic d,
                      input logic [7:0] st, input bit cs);
    exp_t e;
    e.la = la; e.busy = b; e.done = d; e.step = st; e.chk_step = cs;
    sb.push_back(e);
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, "_sb_underflow"}, 64'd1, 64'd0);
    end else begin
      e = sb.pop_front();
      check({tag, "_la_out"}, 64'(la_out), 64'(e.la));
      check({tag, "_busy"},   64'(busy),   64'(e.busy));
      check({tag, "_done"},   64'(done),   64'(e.done));
      if (e.chk_step) check({tag, "_step"}, 64'(step), 64'(e.step));
    end
  endtask

  // Full sweep; also releases reset on its first edge so a start right after
  // reset release can be exercised. div is scrambled after start is taken.
  task automatic sweep(input string tag, input logic [1:0] m, input logic [DW-1:0] d,
                       input int noise_idx, input bit noise_done);
    logic [NP-1:0] exp_err;
    exp_err = '0;
    @(negedge clk);
    rst_n = 1'b1;
    mode  = m;
    div   = d;
    start = 1'b1;
    for (int k = 0; k < NP; k++) begin
      for (int c = 0; c <= int'(d); c++) push(pat(k, m[0]), 1'b1, 1'b0, 8'(k), 1'b1);
      exp_err |= pat(k, m[0]) & stuck0;
    end
    push(pat(NP - 1, m[0]), 1'b0, 1'b1, 8'(NP - 1), 1'b1);
    push('0, 1'b0, 1'b0, 8'd0, 1'b0);
    @(negedge clk);
    div = ~d;
    for (int n = 0; sb.size() > 0; n++) begin
      start = 1'b0;
      pop_check(tag);
      if (n == noise_idx || (noise_done && sb.size() == 1)) start = 1'b1;
      @(negedge clk);
    end
    start = 1'b0;
    check({tag, "_err_mask"}, 64'(err_mask), 64'(exp_err));
    check({tag, "_no_restart"}, 64'(busy), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; mode = 2'd0;
    static_val = '0; div = '0; stuck0 = '0;
    #12;
    check("reset_la_out", 64'(la_out),   64'd0);
    check("reset_busy",   64'(busy),     64'd0);
    check("reset_done",   64'(done),     64'd0);
    check("reset_step",   64'(step),     64'd0);
    check("reset_err",    64'(err_mask), 64'd0);

    // Walking one, one cycle per step, clean loopback, start pulses in RUN and DONE.
    sweep("walk1_div0", 2'd2, 4'd0, 1, 1'b1);

    // Walking zero, three cycles per step, pin 2 stuck low.
    stuck0 = 4'b0100;
    sweep("walk0_div2", 2'd3, 4'd2, 4, 1'b1);
    stuck0 = 4'b0000;

    // Static mode: start ignored, pins follow static_val one cycle later.
    @(negedge clk);
    mode = 2'd1; static_val = 4'b1010; start = 1'b1;
    push(4'b1010, 1'b0, 1'b0, 8'd0, 1'b0);
    push(4'b1010, 1'b0, 1'b0, 8'd0, 1'b0);
    @(negedge clk); start = 1'b0; pop_check("static");
    @(negedge clk); mode = 2'd0; pop_check("static_hold");
    push(4'b0000, 1'b0, 1'b0, 8'd0, 1'b0);
    @(negedge clk); pop_check("zero_mode");

    // Abort at step 2 with pin 0 stuck low so err_mask has something to keep.
    stuck0 = 4'b0001;
    @(negedge clk);
    mode = 2'd2; div = 4'd0; start = 1'b1;
    push(4'b0001, 1'b1, 1'b0, 8'd0, 1'b1);
    push(4'b0010, 1'b1, 1'b0, 8'd1, 1'b1);
    push(4'b0100, 1'b1, 1'b0, 8'd2, 1'b1);
    push(4'b0100, 1'b0, 1'b0, 8'd0, 1'b0);
    push(4'b0000, 1'b0, 1'b0, 8'd0, 1'b0);
    @(negedge clk); start = 1'b0; pop_check("abort_s0");
    @(negedge clk); pop_check("abort_s1");
    @(negedge clk); pop_check("abort_s2"); abort = 1'b1;
    @(negedge clk); abort = 1'b0; pop_check("abort_next");
    @(negedge clk); pop_check("abort_idle");
    check("abort_err_kept", 64'(err_mask), 64'd1);
    check("abort_no_done",  64'(done),     64'd0);
    stuck0 = 4'b0000;

    // A clean sweep clears the error flags left by the aborted one.
    sweep("walk1_clear", 2'd2, 4'd1, -1, 1'b0);

    // Reset mid-RUN: outputs drop before the next clock edge.
    @(negedge clk);
    mode = 2'd2; div = 4'd1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (2) @(negedge clk);
    check("pre_reset_busy", 64'(busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_la_out", 64'(la_out),   64'd0);
    check("midrst_busy",   64'(busy),     64'd0);
    check("midrst_done",   64'(done),     64'd0);
    check("midrst_step",   64'(step),     64'd0);
    check("midrst_err",    64'(err_mask), 64'd0);

    // Start on the first edge after release runs a full sweep.
    stuck0 = 4'b1000;
    sweep("after_reset", 2'd2, 4'd0, -1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
